sim_end_ctrl: RTL and testbench
===============================

Name: sim_end_ctrl

Overview:
- Testbench end-of-simulation controller; sits directly upstream of the clock/reset generator and drives its end-of-simulation input.
- Clocked by the generated clock; collects per-source done flags and error pulses, applies a drain period, enforces a cycle-count watchdog, and asserts a sticky end-of-simulation flag with a pass/fail/timeout verdict.

Parameters:
- N_SRC, 4, number of stimulus/checker sources reporting done and errors
- DRAIN_CYCLES, 16, cycles to wait after all sources are done before ending (0 allowed)
- TIMEOUT_CYCLES, 100000, watchdog limit in cycles since reset release (0 = watchdog disabled)
- CNT_WIDTH, 32, width of the cycle counter

Ports:
- Clk_CI  in  1  clock; one clock domain
- Rst_RI  in  1  reset, synchronous, active-high
- Done_SI  in  N_SRC  per-source done level; captured sticky
- Error_SI  in  N_SRC  per-source error pulse, one error per set bit per cycle
- Abort_SI  in  1  immediate failing end request
- EndOfSim_SO  out  1  end-of-simulation flag, sticky until reset
- Status_DO  out  2  00 running, 01 pass, 10 fail, 11 timeout
- DoneMask_DO  out  N_SRC  sticky captured done bits
- ErrCnt_DO  out  16  total errors, saturating at 16'hFFFF
- CycleCnt_DO  out  CNT_WIDTH  cycles since reset release, saturating, frozen in END

Behaviour:
- Reset (Rst_RI=1 at an edge): state RUN; all outputs 0; drain counter 0. Reset mid-operation, including in END, restarts cleanly; EndOfSim_SO drops after the reset edge.
- FSM states: RUN, DRAIN, END. EndOfSim_SO = (state==END), registered.
- CycleCnt: increments every edge in RUN and DRAIN, saturates at all-ones, holds in END.
- DoneMask: in RUN, DoneMask <= DoneMask | Done_SI. Done_SI is ignored in DRAIN and END.
- ErrCnt: in RUN and DRAIN, ErrCnt <= sat(ErrCnt + popcount(Error_SI)). Ignored in END.
- Transition priority at each edge in RUN or DRAIN, highest first:
  1. Abort_SI=1 -> END, Status 10.
  2. TIMEOUT_CYCLES!=0 and CycleCnt==TIMEOUT_CYCLES-1 -> END, Status 11. EndOfSim therefore rises after edge number TIMEOUT_CYCLES following reset release.
  3. RUN and (DoneMask|Done_SI) all ones: if DRAIN_CYCLES==0 -> END; else -> DRAIN with drain counter = DRAIN_CYCLES-1.
  4. DRAIN and drain counter==0 -> END. Otherwise decrement the counter.
- Drain latency: if edge e0 completes the mask, EndOfSim_SO is high after edge e0+DRAIN_CYCLES.
- Verdict on entry to END via rule 3 or 4:
  - Status 01 only if ErrCnt==0 and Error_SI==0 on the entry edge.
  - Otherwise Status 10.
- Error pulse on the same edge as an abort or timeout: still counted; verdict remains 10 or 11 respectively.
- Status_DO is 00 in RUN and DRAIN, updated on the END entry edge, and held in END.
- Errors do not end the simulation early; only abort, timeout, or drain completion do.
- N_SRC=1 is legal. All Done_SI bits set on the first edge after reset is legal (zero-length RUN).
- No combinational paths from inputs to outputs.

Test Plan:
- Pass path: N_SRC=4, DRAIN=16. Done bits set one at a time at cycles 10, 20, 30, 40 (bit 3 last at edge 40) -> DoneMask 4'hF; EndOfSim_SO rises after edge 56; Status 01; CycleCnt frozen at 56.
- Error in drain: same as above plus Error_SI=4'b0101 at cycle 45 -> ErrCnt 2; EndOfSim after edge 56; Status 10.
- Timeout: TIMEOUT=200, Done_SI held at 4'b0111 -> EndOfSim after edge 200; Status 11; CycleCnt 200; DoneMask 4'h7.
- Simultaneous events: Abort_SI and the completing Done_SI bit on the same edge 30 -> END after edge 30, Status 10. A separate run with DRAIN=0 and the completing done at edge 30 -> END after edge 30, Status 01.
- ErrCnt saturation: Error_SI=4'hF held for 20000 cycles -> ErrCnt 16'hFFFF and held, no wrap to 0.
- Reset in END: assert Rst_RI for 1 edge -> all outputs 0, state RUN. A subsequent pass run behaves identically to the first scenario.

Source files
------------

// File: rtl/sim_end_ctrl.sv
// End-of-simulation controller: gathers per-source done/error reports, drains,
// runs a cycle watchdog and raises a sticky end flag with a pass/fail/timeout verdict.
module sim_end_ctrl #(
  parameter int unsigned N_SRC          = 4,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic [N_SRC-1:0]     Done_SI,
  input  logic [N_SRC-1:0]     Error_SI,
  input  logic                 Abort_SI,
  output logic                 EndOfSim_SO,
  output logic [1:0]           Status_DO,
  output logic [N_SRC-1:0]     DoneMask_DO,
  output logic [15:0]          ErrCnt_DO,
  output logic [CNT_WIDTH-1:0] CycleCnt_DO
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_END   = 2'd2
  } state_e;

  localparam int unsigned DRW = (DRAIN_CYCLES > 32'd1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned PCW = $clog2(N_SRC + 1);

  localparam logic [1:0] STAT_RUN     = 2'b00;
  localparam logic [1:0] STAT_PASS    = 2'b01;
  localparam logic [1:0] STAT_FAIL    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  function automatic logic [PCW-1:0] popcount(input logic [N_SRC-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < N_SRC; i++) begin
      c = c + PCW'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [PCW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    if (s[16]) begin
      return 16'hFFFF;
    end else begin
      return s[15:0];
    end
  endfunction

  state_e               state_q, state_d;
  logic [DRW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [N_SRC-1:0]     done_mask_q, done_mask_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [1:0]           status_q, status_d;
  logic                 eos_q, eos_d;

  logic active_s;
  logic mask_all_s;
  logic timeout_hit_s;

  assign active_s      = (state_q != ST_END);
  assign mask_all_s    = &(done_mask_q | Done_SI);
  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) &&
                         (cycle_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1));

  // State register
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort > watchdog > mask completion > drain expiry
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (Abort_SI) begin
          state_d = ST_END;
        end else if (timeout_hit_s) begin
          state_d = ST_END;
        end else if ((state_q == ST_RUN) && mask_all_s) begin
          if (DRAIN_CYCLES == 32'd0) begin
            state_d = ST_END;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRW'(DRAIN_CYCLES - 32'd1);
          end
        end else if (state_q == ST_DRAIN) begin
          if (drain_cnt_q == DRW'(0)) begin
            state_d = ST_END;
          end else begin
            drain_cnt_d = drain_cnt_q - DRW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Verdict is latched on the END entry edge; an error arriving on that edge still fails it
  always_comb begin
    eos_d    = (state_d == ST_END);
    status_d = status_q;
    if (active_s && (state_d == ST_END)) begin
      if (Abort_SI) begin
        status_d = STAT_FAIL;
      end else if (timeout_hit_s) begin
        status_d = STAT_TIMEOUT;
      end else if ((err_cnt_q == 16'd0) && (Error_SI == '0)) begin
        status_d = STAT_PASS;
      end else begin
        status_d = STAT_FAIL;
      end
    end else if (state_d != ST_END) begin
      status_d = STAT_RUN;
    end else begin
      status_d = status_q;
    end
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    done_mask_d = done_mask_q;
    err_cnt_d   = err_cnt_q;
    if (active_s) begin
      if (~&cycle_cnt_q) begin
        cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
      end else begin
        cycle_cnt_d = cycle_cnt_q;
      end
      err_cnt_d = sat_add16(err_cnt_q, popcount(Error_SI));
    end else begin
      cycle_cnt_d = cycle_cnt_q;
      err_cnt_d   = err_cnt_q;
    end
    if (state_q == ST_RUN) begin
      done_mask_d = done_mask_q | Done_SI;
    end else begin
      done_mask_d = done_mask_q;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      done_mask_q <= '0;
      err_cnt_q   <= 16'd0;
      status_q    <= STAT_RUN;
      eos_q       <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_mask_q <= done_mask_d;
      err_cnt_q   <= err_cnt_d;
      status_q    <= status_d;
      eos_q       <= eos_d;
    end
  end

  assign EndOfSim_SO = eos_q;
  assign Status_DO   = status_q;
  assign DoneMask_DO = done_mask_q;
  assign ErrCnt_DO   = err_cnt_q;
  assign CycleCnt_DO = cycle_cnt_q;

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Directed bench for sim_end_ctrl: default, short-timeout and zero-drain instances
// share stimulus; each scenario checks the instance it targets.
module tb_sim_end_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] done = 4'd0;
  logic [3:0] err = 4'd0;
  logic       abort = 1'b0;

  logic        eos_a, eos_t, eos_z;
  logic [1:0]  st_a, st_t, st_z;
  logic [3:0]  mask_a, mask_t, mask_z;
  logic [15:0] ec_a, ec_t, ec_z;
  logic [31:0] cyc_a, cyc_t, cyc_z;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  sim_end_ctrl #(.N_SRC(4), .DRAIN_CYCLES(16), .TIMEOUT_CYCLES(100000), .CNT_WIDTH(32)) dut_a (
    .Clk_CI(clk), .Rst_RI(rst), .Done_SI(done), .Error_SI(err), .Abort_SI(abort),
    .EndOfSim_SO(eos_a), .Status_DO(st_a), .DoneMask_DO(mask_a), .ErrCnt_DO(ec_a),
    .CycleCnt_DO(cyc_a)
  );

  sim_end_ctrl #(.N_SRC(4), .DRAIN_CYCLES(16), .TIMEOUT_CYCLES(200), .CNT_WIDTH(32)) dut_t (
    .Clk_CI(clk), .Rst_RI(rst), .Done_SI(done), .Error_SI(err), .Abort_SI(abort),
    .EndOfSim_SO(eos_t), .Status_DO(st_t), .DoneMask_DO(mask_t), .ErrCnt_DO(ec_t),
    .CycleCnt_DO(cyc_t)
  );

  sim_end_ctrl #(.N_SRC(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100000), .CNT_WIDTH(32)) dut_z (
    .Clk_CI(clk), .Rst_RI(rst), .Done_SI(done), .Error_SI(err), .Abort_SI(abort),
    .EndOfSim_SO(eos_z), .Status_DO(st_z), .DoneMask_DO(mask_z), .ErrCnt_DO(ec_z),
    .CycleCnt_DO(cyc_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    done  = 4'd0;
    err   = 4'd0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  task automatic pass_run(input string pfx, input bit with_err);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_to(10 * (i + 1) - 1);
      done = 4'b0001 << i;
      step();
      done = 4'd0;
    end
    check_eq({pfx, "_mask40"}, 32'(mask_a), 32'hF);
    check_eq({pfx, "_eos40"}, 32'(eos_a), 32'd0);
    check_eq({pfx, "_st40"}, 32'(st_a), 32'd0);
    if (with_err) begin
      run_to(44);
      err = 4'b0101;
      step();
      err = 4'd0;
      check_eq({pfx, "_errcnt45"}, 32'(ec_a), 32'd2);
      check_eq({pfx, "_eos45"}, 32'(eos_a), 32'd0);
    end
    run_to(55);
    check_eq({pfx, "_eos55"}, 32'(eos_a), 32'd0);
    step();
    check_eq({pfx, "_eos56"}, 32'(eos_a), 32'd1);
    check_eq({pfx, "_st56"}, 32'(st_a), with_err ? 32'd2 : 32'd1);
    check_eq({pfx, "_cyc56"}, cyc_a, 32'd56);
    run_to(60);
    check_eq({pfx, "_cyc_frozen"}, cyc_a, 32'd56);
    check_eq({pfx, "_eos_sticky"}, 32'(eos_a), 32'd1);
  endtask

  initial begin
    do_reset();
    check_eq("rst_eos", 32'(eos_a), 32'd0);
    check_eq("rst_st", 32'(st_a), 32'd0);
    check_eq("rst_mask", 32'(mask_a), 32'd0);
    check_eq("rst_ec", 32'(ec_a), 32'd0);
    check_eq("rst_cyc", cyc_a, 32'd0);

    pass_run("pass1", 1'b0);

    // reset while in END
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    check_eq("rend_eos", 32'(eos_a), 32'd0);
    check_eq("rend_st", 32'(st_a), 32'd0);
    check_eq("rend_mask", 32'(mask_a), 32'd0);
    check_eq("rend_cyc", cyc_a, 32'd0);
    check_eq("rend_ec", 32'(ec_a), 32'd0);

    pass_run("pass2", 1'b0);
    pass_run("drainerr", 1'b1);

    // watchdog on the TIMEOUT=200 instance
    do_reset();
    done = 4'b0111;
    run_to(199);
    check_eq("to_eos199", 32'(eos_t), 32'd0);
    step();
    check_eq("to_eos200", 32'(eos_t), 32'd1);
    check_eq("to_st", 32'(st_t), 32'd3);
    check_eq("to_cyc", cyc_t, 32'd200);
    check_eq("to_mask", 32'(mask_t), 32'h7);
    done = 4'd0;

    // abort together with the completing done bit
    do_reset();
    run_to(9);
    done = 4'b0111;
    step();
    done = 4'd0;
    run_to(29);
    done  = 4'hF;
    abort = 1'b1;
    step();
    done  = 4'd0;
    abort = 1'b0;
    check_eq("abort_eos", 32'(eos_a), 32'd1);
    check_eq("abort_st", 32'(st_a), 32'd2);
    check_eq("abort_cyc", cyc_a, 32'd30);

    // zero-drain instance ends on the completing edge
    do_reset();
    run_to(9);
    done = 4'b0111;
    step();
    done = 4'd0;
    run_to(29);
    check_eq("d0_eos29", 32'(eos_z), 32'd0);
    done = 4'hF;
    step();
    done = 4'd0;
    check_eq("d0_eos30", 32'(eos_z), 32'd1);
    check_eq("d0_st", 32'(st_z), 32'd1);
    check_eq("d0_cyc", cyc_z, 32'd30);
    check_eq("d16_eos30", 32'(eos_a), 32'd0);

    // error counter saturation, errors alone never end the run
    do_reset();
    err = 4'hF;
    run_to(16383);
    check_eq("sat_pre", 32'(ec_a), 32'd65532);
    step();
    check_eq("sat_hit", 32'(ec_a), 32'hFFFF);
    run_to(20000);
    check_eq("sat_hold", 32'(ec_a), 32'hFFFF);
    check_eq("sat_eos", 32'(eos_a), 32'd0);
    check_eq("sat_st", 32'(st_a), 32'd0);
    check_eq("sat_cyc", cyc_a, 32'd20000);
    err = 4'd0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
